i2c_xfer_sequencer: RTL and testbench
=====================================

# i2c_xfer_sequencer

Transaction-level sequencer that sits directly upstream of the I2C byte engine in the serial-EEPROM runtimes. It turns one host command into the complete chain of byte-engine operations for that command: page write, random/sequential read, or ACK poll. Each operation sets start, data, ack and stop controls. A 16-byte data buffer holds the payload, and a per-byte timeout reports a missing ACK so the engine never hangs.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'hFFFF, clock cycles allowed per byte before abort
- DEVTYPE, 4'b1010, device-type nibble placed in bits 7:4 of the device-select byte

Ports:
- clock  in  1  sequencer clock, also the engine's clock
- nreset  in  1  reset, asynchronous, active-low
- cmd_go  in  1  one-cycle command strobe; ignored unless idle
- cmd_op  in  2  0=WRITE, 1=READ, 2=POLL, 3=reserved (treated as POLL)
- cmd_len  in  4  byte count minus one (1..16 bytes)
- cmd_blk  in  3  block/chip-enable bits for device-select bits 3:1
- cmd_addr  in  8  word address inside the block
- buf_wr  in  1  host buffer write strobe (honoured only when idle)
- buf_idx  in  4  host buffer index (write and read)
- buf_wdata  in  8  host buffer write data
- buf_rdata  out  8  buffer[buf_idx], combinational
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- error  out  1  sticky timeout flag, cleared by the next accepted cmd_go
- eng_nreset  out  1  engine reset, active-low
- eng_start  out  1  one-cycle pulse launching one byte operation
- eng_write_byte  out  8  byte to transmit
- eng_read_mode  out  1  1 = receive byte
- eng_do_start  out  1  prefix start/restart condition
- eng_expect_ack  out  1  run ACK phase after the byte
- eng_do_stop  out  1  append stop condition
- eng_read_byte  in  8  received byte, valid when eng_finished rises
- eng_finished  in  1  engine idle/complete level

## Operation
- Reset values:
  - busy=0, done=0, error=0, eng_start=0.
  - eng_nreset=1.
  - All eng_* control bits=0, eng_write_byte=0, buf_rdata follows the buffer.
  - Buffer contents: 0.
  - State: IDLE.
- States: IDLE, DEVW, ADDR, WDATA, DEVR, RDATA, ABORT. Each byte state runs the sub-states ISSUE → WAIT_LO → WAIT_HI.
  - ISSUE drives eng_* controls and pulses eng_start.
  - WAIT_LO waits for eng_finished=0.
  - WAIT_HI waits for eng_finished=1, then advances.
- WRITE: DEVW(start, ack, byte {DEVTYPE,blk,0}) → ADDR(ack, cmd_addr) → WDATA ×(len+1). Each WDATA byte is buffer[i] with ack; the last byte also sets stop.
- READ: DEVW → ADDR → DEVR(start=restart, ack, byte {DEVTYPE,blk,1}) → RDATA ×(len+1). Each RDATA byte has read_mode=1.
  - Bytes 0..len-1 run with ack (master ACK).
  - The last byte runs with ack=0 and stop=1.
  - Byte i is stored into buffer[i] on WAIT_HI exit.
- POLL: DEVW with start, ack and stop; no data.
- Index counter: 4 bits, starts at 0, increments per data byte. The data phase ends when index==cmd_len. len=15 stores into index 15 with no wrap.
- Command fields are latched on accept and host changes mid-command have no effect. buf_wr while busy is dropped.
- Timeout: a 16-bit counter reloads on every ISSUE and decrements in WAIT_LO/WAIT_HI. At zero the block enters ABORT:
  - eng_nreset=0 for 2 cycles.
  - error is set.
  - done is pulsed.
  - The block returns to IDLE.
  - A POLL timeout means "device busy" (no ACK).

## Timing
- cmd_go accepted in IDLE at cycle T: busy=1 at T+1, first eng_start at T+1.
- eng_start is exactly 1 cycle wide. eng_* controls are stable from eng_start until the WAIT_HI exit.
- Byte latency = engine time + 3 cycles of sequencer overhead.
- On the final byte's WAIT_HI exit at cycle F: done=1 and busy=0 at F+1. A cmd_go at F+1 is accepted.
- cmd_go and buf_wr in the same cycle while idle: both honoured.
- nreset mid-command: immediate IDLE, outputs at reset values, buffer cleared.
- If eng_finished is already 0 in ISSUE, that is fine: WAIT_LO passes immediately.

## Test plan
- WRITE, len=1, blk=3, addr=0x40, buffer={0xA5,0x5A}, engine model ACKs → bytes 0xA6, 0x40, 0xA5, 0x5A; only the last has stop, only the first has start; done once, error=0.
- READ, len=2, blk=0, addr=0x10, model returns 0x11,0x22,0x33 → sequence 0xA0, 0x10, restart 0xA1, then 3 reads with ack=1,1,0; stop on the last; buf_rdata[0..2]=0x11,0x22,0x33.
- POLL with the model never finishing, TIMEOUT_CYCLES=20 → eng_nreset low for 2 cycles about 20 cycles after eng_start; error=1; done pulse; the next cmd_go clears error.
- len=15 READ → 16 stores, index 15 written last, no wrap into index 0.
- nreset asserted during WDATA byte 3 → busy=0 and eng_start=0 asynchronously; after release, a fresh WRITE completes correctly.
- cmd_go while busy and buf_wr while busy → both ignored; buffer and command fields unchanged.

Source files
------------

// File: rtl/i2c_xfer_sequencer.sv
// Expands one host command into the I2C byte-engine operation chain (page write, read, ACK poll).
// Each byte costs engine time plus 3 cycles (ISSUE, WAIT_LO, WAIT_HI); a per-byte timeout aborts a stalled engine.
module i2c_xfer_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
  parameter logic [3:0]  DEVTYPE        = 4'b1010
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       cmd_go,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_len,
  input  logic [2:0] cmd_blk,
  input  logic [7:0] cmd_addr,
  input  logic       buf_wr,
  input  logic [3:0] buf_idx,
  input  logic [7:0] buf_wdata,
  output logic [7:0] buf_rdata,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       eng_nreset,
  output logic       eng_start,
  output logic [7:0] eng_write_byte,
  output logic       eng_read_mode,
  output logic       eng_do_start,
  output logic       eng_expect_ack,
  output logic       eng_do_stop,
  input  logic [7:0] eng_read_byte,
  input  logic       eng_finished
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEVW  = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_DEVR  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_ABORT = 3'd6;

  localparam logic [1:0] P_ISSUE   = 2'd0;
  localparam logic [1:0] P_WAIT_LO = 2'd1;
  localparam logic [1:0] P_WAIT_HI = 2'd2;

  logic [2:0]  state, next_state;
  logic [1:0]  phase;
  logic [1:0]  op_q;
  logic [3:0]  len_q;
  logic [2:0]  blk_q;
  logic [7:0]  addr_q;
  logic [3:0]  idx;
  logic [15:0] tmo;
  logic        abort_cnt;
  logic [7:0]  buffer [16];

  logic is_write, is_poll, last_data, byte_state, is_data;

  assign is_write   = (op_q == 2'd0);
  assign is_poll    = op_q[1];
  assign last_data  = (idx == len_q);
  assign byte_state = (state != S_IDLE) && (state != S_ABORT);
  assign is_data    = (state == S_WDATA) || (state == S_RDATA);

  assign busy       = (state != S_IDLE);
  assign eng_nreset = (state != S_ABORT);
  assign eng_start  = byte_state && (phase == P_ISSUE);
  assign buf_rdata  = buffer[buf_idx];

  // Controls depend only on state, index and latched fields, so they hold for the whole byte.
  always_comb begin
    eng_write_byte = 8'h00;
    eng_read_mode  = 1'b0;
    eng_do_start   = 1'b0;
    eng_expect_ack = 1'b0;
    eng_do_stop    = 1'b0;
    next_state     = S_IDLE;
    case (state)
      S_DEVW: begin
        eng_write_byte = {DEVTYPE, blk_q, 1'b0};
        eng_do_start   = 1'b1;
        eng_expect_ack = 1'b1;
        eng_do_stop    = is_poll;
        next_state     = is_poll ? S_IDLE : S_ADDR;
      end
      S_ADDR: begin
        eng_write_byte = addr_q;
        eng_expect_ack = 1'b1;
        next_state     = is_write ? S_WDATA : S_DEVR;
      end
      S_WDATA: begin
        eng_write_byte = buffer[idx];
        eng_expect_ack = 1'b1;
        eng_do_stop    = last_data;
        next_state     = last_data ? S_IDLE : S_WDATA;
      end
      S_DEVR: begin
        eng_write_byte = {DEVTYPE, blk_q, 1'b1};
        eng_do_start   = 1'b1;
        eng_expect_ack = 1'b1;
        next_state     = S_RDATA;
      end
      S_RDATA: begin
        eng_read_mode  = 1'b1;
        eng_expect_ack = !last_data;
        eng_do_stop    = last_data;
        next_state     = last_data ? S_IDLE : S_RDATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 16; i++) buffer[i] <= 8'h00;
    end else if (state == S_IDLE && buf_wr) begin
      buffer[buf_idx] <= buf_wdata;
    end else if (state == S_RDATA && phase == P_WAIT_HI && eng_finished) begin
      buffer[idx] <= eng_read_byte;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      phase     <= P_ISSUE;
      op_q      <= 2'd0;
      len_q     <= 4'd0;
      blk_q     <= 3'd0;
      addr_q    <= 8'h00;
      idx       <= 4'd0;
      tmo       <= 16'd0;
      abort_cnt <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_go) begin
            op_q   <= cmd_op;
            len_q  <= cmd_len;
            blk_q  <= cmd_blk;
            addr_q <= cmd_addr;
            idx    <= 4'd0;
            error  <= 1'b0;
            phase  <= P_ISSUE;
            state  <= S_DEVW;
          end
        end
        S_ABORT: begin
          abort_cnt <= !abort_cnt;
          if (abort_cnt) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          case (phase)
            P_ISSUE: begin
              tmo   <= TIMEOUT_CYCLES;
              phase <= P_WAIT_LO;
            end
            P_WAIT_LO: begin
              if (!eng_finished) begin
                phase <= P_WAIT_HI;
              end else if (tmo == 16'd0) begin
                state <= S_ABORT;
                error <= 1'b1;
              end else begin
                tmo <= tmo - 16'd1;
              end
            end
            default: begin
              if (eng_finished) begin
                phase <= P_ISSUE;
                state <= next_state;
                if (next_state == S_IDLE) done <= 1'b1;
                if (is_data && !last_data) idx <= idx + 4'd1;
              end else if (tmo == 16'd0) begin
                state <= S_ABORT;
                error <= 1'b1;
              end else begin
                tmo <= tmo - 16'd1;
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench: a command-level model queues the expected engine operations, a monitor pops them on eng_start.
module tb_i2c_xfer_sequencer;
  localparam logic [15:0] TMO = 16'd20;
  localparam logic [3:0]  DEV = 4'b1010;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       cmd_go = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [3:0] cmd_len = 4'd0;
  logic [2:0] cmd_blk = 3'd0;
  logic [7:0] cmd_addr = 8'h00;
  logic       buf_wr = 1'b0;
  logic [3:0] buf_idx = 4'd0;
  logic [7:0] buf_wdata = 8'h00;
  logic [7:0] buf_rdata;
  logic       busy, done, error, eng_nreset, eng_start;
  logic [7:0] eng_write_byte;
  logic       eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop;
  logic [7:0] eng_read_byte = 8'h00;
  logic       eng_finished = 1'b1;

  i2c_xfer_sequencer #(.TIMEOUT_CYCLES(TMO), .DEVTYPE(DEV)) dut (
    .clock(clock), .nreset(nreset), .cmd_go(cmd_go), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_blk(cmd_blk), .cmd_addr(cmd_addr), .buf_wr(buf_wr), .buf_idx(buf_idx),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .busy(busy), .done(done), .error(error),
    .eng_nreset(eng_nreset), .eng_start(eng_start), .eng_write_byte(eng_write_byte),
    .eng_read_mode(eng_read_mode), .eng_do_start(eng_do_start), .eng_expect_ack(eng_expect_ack),
    .eng_do_stop(eng_do_stop), .eng_read_byte(eng_read_byte), .eng_finished(eng_finished)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] b;
    logic       st;
    logic       ack;
    logic       sp;
    logic       rd;
  } op_t;

  op_t        exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] buf_model [16];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_start_cyc = 0;
  int         abort_delay = -1;
  int         nrst_run = 0;
  int         nrst_low = 0;
  int         done_cnt = 0;
  logic       prev_start = 1'b0;
  logic       eng_active = 1'b0;
  logic       eng_hang = 1'b0;
  int         eng_wait = 0;
  op_t        cap;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic op_t mk_op(input logic [7:0] b, input logic st, input logic ack,
                                input logic sp, input logic rd);
    op_t o;
    o.b = b; o.st = st; o.ack = ack; o.sp = sp; o.rd = rd;
    return o;
  endfunction

  // Reference model: the operation list a command must produce, built from the protocol rules.
  task automatic push_expected(input logic [1:0] op, input logic [3:0] len,
                               input logic [2:0] blk, input logic [7:0] addr);
    int n;
    logic poll;
    n = int'(len) + 1;
    poll = (op >= 2'd2);
    exp_q.push_back(mk_op({DEV, blk, 1'b0}, 1'b1, 1'b1, poll, 1'b0));
    if (!poll) begin
      exp_q.push_back(mk_op(addr, 1'b0, 1'b1, 1'b0, 1'b0));
      if (op == 2'd0) begin
        for (int i = 0; i < n; i++)
          exp_q.push_back(mk_op(buf_model[i], 1'b0, 1'b1, i == n - 1, 1'b0));
      end else begin
        exp_q.push_back(mk_op({DEV, blk, 1'b1}, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < n; i++)
          exp_q.push_back(mk_op(8'h00, 1'b0, i != n - 1, i == n - 1, 1'b1));
      end
    end
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clock);
    if (eng_start) begin
      op_t e;
      check("start_width", 32'(prev_start), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_op: got byte %0h want no operation", eng_write_byte);
      end else begin
        e = exp_q.pop_front();
        check("op_do_start", 32'(eng_do_start), 32'(e.st));
        check("op_ack", 32'(eng_expect_ack), 32'(e.ack));
        check("op_stop", 32'(eng_do_stop), 32'(e.sp));
        check("op_read_mode", 32'(eng_read_mode), 32'(e.rd));
        if (!e.rd) check("op_byte", 32'(eng_write_byte), 32'(e.b));
      end
    end
    prev_start = eng_start;
    if (eng_start) last_start_cyc = cyc;
    if (!eng_nreset) begin
      if (nrst_run == 0) abort_delay = cyc - last_start_cyc;
      nrst_run++;
    end else if (nrst_run != 0) begin
      nrst_low = nrst_run;
      nrst_run = 0;
    end
    if (done) done_cnt++;
  end

  // Byte-engine model
  initial forever begin
    @(negedge clock);
    if (!nreset || !eng_nreset) begin
      eng_finished = 1'b1;
      eng_active = 1'b0;
    end else if (eng_active) begin
      if (!eng_hang) begin
        if (eng_wait == 0) begin
          check("ctrl_stable",
                32'({eng_write_byte, eng_do_start, eng_expect_ack, eng_do_stop, eng_read_mode}),
                32'(cap));
          if (eng_read_mode) begin
            eng_read_byte = 8'($urandom);
            rd_q.push_back(eng_read_byte);
          end
          eng_finished = 1'b1;
          eng_active = 1'b0;
        end else begin
          eng_wait--;
        end
      end
    end else if (eng_start) begin
      cap = {eng_write_byte, eng_do_start, eng_expect_ack, eng_do_stop, eng_read_mode};
      eng_finished = 1'b0;
      eng_active = 1'b1;
      eng_wait = $urandom_range(1, 4);
    end
  end

  task automatic host_wr(input logic [3:0] i, input logic [7:0] d);
    @(negedge clock);
    buf_wr = 1'b1; buf_idx = i; buf_wdata = d;
    buf_model[i] = d;
    @(negedge clock);
    buf_wr = 1'b0;
  endtask

  task automatic check_buffer();
    for (int i = 0; i < 16; i++) begin
      buf_idx = 4'(i);
      #1;
      check("buf_rdata", 32'(buf_rdata), 32'(buf_model[i]));
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] len, input logic [2:0] blk,
                         input logic [7:0] addr, input logic hang, input logic meddle,
                         input logic co_wr);
    int d0;
    logic seen;
    logic [3:0] wi;
    logic [7:0] wd;
    @(negedge clock);
    if (co_wr) begin
      wi = 4'($urandom); wd = 8'($urandom);
      buf_wr = 1'b1; buf_idx = wi; buf_wdata = wd;
      buf_model[wi] = wd;
    end
    rd_q.delete();
    push_expected(op, len, blk, addr);
    eng_hang = hang;
    cmd_go = 1'b1; cmd_op = op; cmd_len = len; cmd_blk = blk; cmd_addr = addr;
    d0 = done_cnt;
    @(negedge clock);
    cmd_go = 1'b0; buf_wr = 1'b0;
    check("busy_T1", 32'(busy), 32'd1);
    check("start_T1", 32'(eng_start), 32'd1);
    check("error_cleared", 32'(error), 32'd0);
    cmd_op = 2'($urandom); cmd_len = 4'($urandom); cmd_blk = 3'($urandom); cmd_addr = 8'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clock);
      if (k == 0 && meddle) begin
        cmd_go = 1'b1; cmd_op = 2'($urandom); cmd_len = 4'($urandom);
        buf_wr = 1'b1; buf_idx = 4'($urandom); buf_wdata = 8'($urandom);
      end else begin
        cmd_go = 1'b0; buf_wr = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) check("busy_at_done", 32'(busy), 32'd0);
    cmd_go = 1'b0; buf_wr = 1'b0;
    repeat (3) @(negedge clock);
    eng_hang = 1'b0;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("error_flag", 32'(error), 32'(hang));
    check("ops_left", 32'(exp_q.size()), 32'd0);
    if (op == 2'd1) begin
      check("read_count", 32'(rd_q.size()), 32'(int'(len) + 1));
      for (int i = 0; i <= int'(len); i++)
        if (rd_q.size() != 0) buf_model[i] = rd_q.pop_front();
    end
    exp_q.delete();
    check_buffer();
  endtask

  initial begin
    int cnt;
    logic [1:0] rop;
    for (int i = 0; i < 16; i++) buf_model[i] = 8'h00;
    nreset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_nreset", 32'(eng_nreset), 32'd1);
    check("rst_eng_ctrl",
          32'({eng_write_byte, eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop}), 32'd0);
    nreset = 1'b1;
    check_buffer();

    host_wr(4'd0, 8'hA5);
    host_wr(4'd1, 8'h5A);
    run_cmd(2'd0, 4'd1, 3'd3, 8'h40, 1'b0, 1'b0, 1'b0);
    run_cmd(2'd1, 4'd2, 3'd0, 8'h10, 1'b0, 1'b0, 1'b0);

    run_cmd(2'd2, 4'd0, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0);
    check("abort_nreset_len", 32'(nrst_low), 32'd2);
    check("abort_delay_ok", 32'(abort_delay >= int'(TMO) && abort_delay <= int'(TMO) + 5), 32'd1);
    run_cmd(2'd3, 4'd0, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0);

    run_cmd(2'd1, 4'd15, 3'd1, 8'h80, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 1) == 1) host_wr(4'($urandom), 8'($urandom));
      rop = 2'($urandom);
      run_cmd(rop, 4'($urandom), 3'($urandom), 8'($urandom),
              (rop >= 2'd2) && ($urandom_range(0, 2) == 0),
              1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 16; i++) host_wr(4'(i), 8'($urandom));
    push_expected(2'd0, 4'd7, 3'd2, 8'h33);
    @(negedge clock);
    cmd_go = 1'b1; cmd_op = 2'd0; cmd_len = 4'd7; cmd_blk = 3'd2; cmd_addr = 8'h33;
    @(negedge clock);
    cmd_go = 1'b0;
    cnt = eng_start ? 1 : 0;
    for (int k = 0; k < 500 && cnt < 6; k++) begin
      @(negedge clock);
      if (eng_start) cnt++;
    end
    check("wdata3_reached", 32'(cnt), 32'd6);
    #2 nreset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_eng_start", 32'(eng_start), 32'd0);
    check("midrst_eng_nreset", 32'(eng_nreset), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) buf_model[i] = 8'h00;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    check_buffer();
    host_wr(4'd0, 8'h3C);
    host_wr(4'd2, 8'hC3);
    run_cmd(2'd0, 4'd3, 3'd6, 8'h7E, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
